// File: rtl/pipelined_carry_adder_if.sv
// Operand/result handshake bundle for pipelined_carry_adder.
// The master side drives operands and out_ready; the slave (the adder) drives the result side.
interface pipelined_carry_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_carry_adder.sv
// Pipelined add/subtract: one CHUNK-bit ripple segment per stage, registered carry between stages.
// Optional signed saturation of the result is enabled by defining PIPE_ADDER_SAT_EN.
module pipelined_carry_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    pipelined_carry_adder_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;

    // Index 0 is the operand capture register; index k holds the result after chunk k-1.
    logic             vld_q   [0:STAGES];
    logic             c_q     [0:STAGES];
    logic [WIDTH-1:0] a_q     [0:STAGES-1];
    logic [WIDTH-1:0] b_q     [0:STAGES-1];
    logic [WIDTH-1:0] sum_q   [1:STAGES];
    logic             ovf_q;

    logic [CHUNK:0]   chunk_sum [1:STAGES];
    logic             c_d       [1:STAGES];
    logic [WIDTH-1:0] acc_d     [1:STAGES];
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;
    logic             a_msb;
    logic             b_msb;
    logic             stall;
    logic             advance;

    assign stall        = vld_q[STAGES] && !bus.out_ready;
    assign advance      = !stall;
    assign bus.in_ready = advance;

    genvar gi;
    generate
        for (gi = 1; gi <= STAGES; gi++) begin : gen_stage
            assign chunk_sum[gi] = {1'b0, a_q[gi-1][(gi-1)*CHUNK +: CHUNK]}
                                 + {1'b0, b_q[gi-1][(gi-1)*CHUNK +: CHUNK]}
                                 + {{CHUNK{1'b0}}, c_q[gi-1]};
            assign c_d[gi] = chunk_sum[gi][CHUNK];
            // Chunks above the current one are still zero in the partial result, so OR inserts cleanly.
            if (gi == 1) begin : gen_first
                assign acc_d[gi] = WIDTH'(chunk_sum[gi][CHUNK-1:0]);
            end else begin : gen_next
                assign acc_d[gi] = sum_q[gi-1]
                                 | (WIDTH'(chunk_sum[gi][CHUNK-1:0]) << ((gi - 1) * CHUNK));
            end
        end
    endgenerate

    assign a_msb = a_q[STAGES-1][WIDTH-1];
    assign b_msb = b_q[STAGES-1][WIDTH-1];
    assign ovf_d = (a_msb == b_msb) && (acc_d[STAGES][WIDTH-1] != a_msb);

`ifdef PIPE_ADDER_SAT_EN
    assign res_d = !ovf_d ? acc_d[STAGES]
                 : (a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign res_d = acc_d[STAGES];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= STAGES; k++) begin
                vld_q[k] <= 1'b0;
                c_q[k]   <= 1'b0;
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int k = 1; k <= STAGES; k++) begin
                sum_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            // Subtraction runs as A + ~B + ~cin; the inversion is folded in at capture time.
            vld_q[0] <= bus.in_valid;
            a_q[0]   <= bus.a;
            b_q[0]   <= bus.sub ? ~bus.b : bus.b;
            c_q[0]   <= bus.sub ? ~bus.cin : bus.cin;
            for (int k = 1; k < STAGES; k++) begin
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
            end
            for (int k = 1; k <= STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                c_q[k]   <= c_d[k];
                sum_q[k] <= (k == STAGES) ? res_d : acc_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign bus.out_valid = vld_q[STAGES];
    assign bus.sum       = sum_q[STAGES];
    assign bus.cout      = c_q[STAGES];
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder (WIDTH=32, CHUNK=8): directed cases plus random traffic.
module tb_pipelined_carry_adder;
    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int STAGES = WIDTH / CHUNK;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipelined_carry_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_carry_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    logic [33:0] exp_q [$];
    logic [31:0] got_q [$];
    logic        prev_stall;
    logic [33:0] held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer arithmetic; ovf means the true signed result left the 32-bit range.
    function automatic logic [33:0] model(input logic [31:0] ia, input logic [31:0] ib,
                                          input logic icin, input logic isub);
        logic [31:0]     s;
        logic            c;
        logic            o;
        longint          sr;
        longint unsigned ua;
        longint unsigned ub;
        ua = 64'(ia);
        ub = 64'(ib);
        if (!isub) begin
            ua = ua + ub + 64'(icin);
            s  = ua[31:0];
            c  = ua[32];
            sr = longint'($signed(ia)) + longint'($signed(ib)) + longint'(icin);
        end else begin
            c  = (ua >= ub + 64'(icin));
            s  = ia - ib - 32'(icin);
            sr = longint'($signed(ia)) - longint'($signed(ib)) - longint'(icin);
        end
        o = (sr > SMAX) || (sr < SMIN);
`ifdef PIPE_ADDER_SAT_EN
        if (o) s = (sr > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
        return {o, c, s};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFFFFFF;
            1:       return 32'h7FFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h00000000;
            default: return $urandom();
        endcase
    endfunction

    // One clock: drive at the falling edge, check 1 time unit later, before the next rising edge.
    task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic icin, input logic isub, input logic ordy, output logic acc);
        logic [33:0] e;
        logic [33:0] o;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a         = ia;
        bus.b         = ib;
        bus.cin       = icin;
        bus.sub       = isub;
        bus.out_ready = ordy;
        #1;
        o = {bus.ovf, bus.cout, bus.sum};
        chk("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !ordy)));
        if (prev_stall && bus.out_valid) chk("hold", 64'(o), 64'(held));
        if (bus.out_valid && ordy) begin
            got_q.push_back(bus.sum);
            if (exp_q.size() == 0) begin
                chk("spurious_result", 64'(exp_q.size()), 64'(1));
            end else begin
                e = exp_q.pop_front();
                chk("sum", 64'(o[31:0]), 64'(e[31:0]));
                chk("cout", 64'(o[32]), 64'(e[32]));
                chk("ovf", 64'(o[33]), 64'(e[33]));
            end
        end
        prev_stall = bus.out_valid && !ordy;
        held       = o;
        acc        = iv && bus.in_ready;
        if (acc) exp_q.push_back(model(ia, ib, icin, isub));
    endtask

    task automatic directed(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                            input logic icin, input logic isub,
                            input logic [31:0] es, input logic ec, input logic eo);
        logic acc;
        step(1'b1, ia, ib, icin, isub, 1'b1, acc);
        chk({tag, "_accept"}, 64'(acc), 64'(1));
        for (int k = 1; k <= STAGES + 1; k++) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
            if (k <= STAGES) chk({tag, "_early"}, 64'(bus.out_valid), 64'(0));
        end
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
        chk({tag, "_sum"}, 64'(bus.sum), 64'(es));
        chk({tag, "_cout"}, 64'(bus.cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
        $display("directed %s: a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
                 tag, ia, ib, icin, isub, bus.sum, bus.cout, bus.ovf);
    endtask

    initial begin
        logic acc;
        int   idx;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        prev_stall    = 1'b0;
        held          = '0;

        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
        chk("reset_sum", 64'(bus.sum), 64'(0));
        chk("reset_cout", 64'(bus.cout), 64'(0));
        chk("reset_ovf", 64'(bus.ovf), 64'(0));
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 64'(bus.in_ready), 64'(1));

        directed("wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        directed("sub_borrow", 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0);
        directed("carry_chain", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
`ifdef PIPE_ADDER_SAT_EN
        directed("ovf_add", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
        directed("ovf_sub", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1);
`else
        directed("ovf_add", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        directed("ovf_sub", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
`endif

        // Back-to-back adds with out_ready low for cycles 5-7.
        got_q.delete();
        idx = 0;
        for (int c = 0; c < 24; c++) begin
            step(idx < 6, 32'(idx + 1), 32'(idx + 1), 1'b0, 1'b0, !(c >= 5 && c <= 7), acc);
            if (c >= 5 && c <= 7) chk("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
            if (acc) idx++;
        end
        chk("bp_count", 64'(got_q.size()), 64'(6));
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            chk("bp_order", 64'(got_q[i]), 64'(2 * (i + 1)));
            $display("backpressure result %0d: sum=%0d", i, got_q[i]);
        end
        chk("bp_drained", 64'(exp_q.size()), 64'(0));

        // Reset while results are in flight and one is being presented.
        for (int c = 0; c < 3; c++) step(1'b1, 32'(10 * (c + 1)), 32'd3, 1'b0, 1'b0, 1'b0, acc);
        for (int k = 0; k < 10 && !bus.out_valid; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        chk("rst_setup_valid", 64'(bus.out_valid), 64'(1));
        rst = 1'b1;
        #1;
        chk("rst_async_drop", 64'(bus.out_valid), 64'(0));
        chk("rst_sum_clear", 64'(bus.sum), 64'(0));
        exp_q.delete();
        prev_stall = 1'b0;
        #2 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
            chk("rst_no_result", 64'(bus.out_valid), 64'(0));
        end
        directed("post_reset", 32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0);

        // Random traffic against the reference model.
        got_q.delete();
        for (int c = 0; c < 10000; c++) begin
            step($urandom_range(0, 9) < 7, pick(), pick(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
        end
        for (int k = 0; k < 20; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
        chk("random_drain", 64'(exp_q.size()), 64'(0));
        $display("random phase: %0d results consumed", got_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
